// File: rtl/matrix_keyboard_scanner.sv
// 4x4 active-low key matrix scanner with tick-based debounce and a
// single-entry key_code/key_valid handshake toward the register block.
module matrix_keyboard_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    rows_s_q, rows_s_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_row_q, cand_row_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic          any_low;
  logic [1:0]    low_row;
  logic          cand_pressed;
  logic          accept;

  // Synchronizer, tick divider and row decode
  always_comb begin
    sync1_d      = row_in;
    rows_s_d     = sync1_q;
    tick         = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    any_low      = ~&rows_s_q;
    cand_pressed = ~rows_s_q[cand_row_q];
    if (!rows_s_q[0])      low_row = 2'd0;
    else if (!rows_s_q[1]) low_row = 2'd1;
    else if (!rows_s_q[2]) low_row = 2'd2;
    else                   low_row = 2'd3;
  end

  // Scan/debounce state machine, advanced only on tick
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_row_d = cand_row_q;
    db_cnt_d   = db_cnt_q;
    key_down_d = key_down_q;
    accept     = 1'b0;
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (any_low) begin
            cand_row_d = low_row;
            db_cnt_d   = '0;
            state_d    = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (cand_pressed) begin
            if (db_cnt_q == DB_LAST) begin
              state_d    = S_PRESSED;
              key_down_d = 1'b1;
              accept     = 1'b1;
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
          end else begin
            state_d = S_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        S_PRESSED: begin
          if (!cand_pressed) begin
            db_cnt_d = '0;
            state_d  = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!cand_pressed) begin
            if (db_cnt_q == DB_LAST) begin
              state_d    = S_SCAN;
              key_down_d = 1'b0;
              col_d      = col_q + 2'd1;
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
          end else begin
            state_d = S_PRESSED;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // Output handshake: an ack in the acceptance cycle frees the slot for the new key
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (key_ack) overrun_d = 1'b0;
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = {cand_row_q, col_q};
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      rows_s_q    <= '1;
      tick_cnt_q  <= '0;
      state_q     <= S_SCAN;
      col_q       <= '0;
      cand_row_q  <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rows_s_q    <= rows_s_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_matrix_keyboard_scanner.sv
// Bench for matrix_keyboard_scanner: key matrix model plus a tick-level
// reference that treats the debounced level as flipping after DEBOUNCE_TICKS
// consecutive disagreeing samples following the first one.
module tb_matrix_keyboard_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       overrun;
  logic [15:0] mask = '0;  // bit r*4+c set = key (row r, col c) held

  int errors = 0;
  int checks = 0;

  // reference model state
  int mcnt, m_col, cand_r, run;
  bit trk, armed, m_down, m_valid, m_ovr;
  logic [3:0]  m_code;
  logic [15:0] snap;

  matrix_keyboard_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // matrix: a held key shorts its row to its column when that column is driven low
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
  end

  function automatic logic [10:0] dut_v();
    return {col_out, key_code, key_valid, key_down, overrun};
  endfunction

  function automatic logic [10:0] exp_v();
    return {~(4'b0001 << m_col), m_code, m_valid, m_down, m_ovr};
  endfunction

  // advance one clock and update the reference with the inputs seen at that edge
  task automatic step();
    logic [15:0] m_at;
    bit a_at, r_at, accept, p;
    m_at = mask; a_at = key_ack; r_at = rst;
    @(posedge clk); #1;
    if (r_at) begin
      mcnt = 0; m_col = 0; cand_r = 0; run = 0; trk = 0; armed = 0;
      m_down = 0; m_valid = 0; m_ovr = 0; m_code = '0; snap = '0;
    end else begin
      mcnt++;
      accept = 0;
      // rows seen at a tick are those present two edges earlier (synchronizer)
      if (mcnt % SD == SD - 2) snap = m_at;
      if (mcnt % SD == 0) begin
        if (!trk) begin
          for (int r = 0; r < 4; r++)
            if (!trk && snap[r*4+m_col]) begin trk = 1; armed = 1; run = 0; cand_r = r; end
          if (!trk) m_col = (m_col + 1) % 4;
        end else begin
          p = snap[cand_r*4+m_col];
          if (p != m_down) begin
            if (!armed) begin armed = 1; run = 0; end
            else begin
              run++;
              if (run == DT) begin
                m_down = p; armed = 0;
                if (p) accept = 1;
                else begin trk = 0; m_col = (m_col + 1) % 4; end
              end
            end
          end else begin
            armed = 0;
            if (!m_down) begin trk = 0; m_col = (m_col + 1) % 4; end
          end
        end
      end
      if (a_at) m_ovr = 0;
      if (accept) begin
        if (!m_valid || a_at) begin m_code = 4'(cand_r*4 + m_col); m_valid = 1; end
        else m_ovr = 1;
      end else if (a_at) m_valid = 0;
    end
  endtask

  task automatic test_reset();
    mask = '0; key_ack = 0; rst = 1;
    repeat (3) step();
    checks++;
    if (dut_v() !== {4'b1110, 4'h0, 3'b000})
      begin errors++; $display("FAIL reset_values: got %b expected %b", dut_v(), {4'b1110, 4'h0, 3'b000}); end
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] ec;
      step();
      ec = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (col_out !== ec || {key_valid, key_down, overrun} !== 3'b000)
        begin errors++; $display("FAIL scan_walk: cycle %0d got col=%b flags=%b expected col=%b flags=000", i, col_out, {key_valid, key_down, overrun}, ec); end
    end
  endtask

  task automatic test_press_ack_release();
    int det = -1;
    bit ok = 0;
    mask = 16'h1 << 9;
    for (int i = 0; i < 200; i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL press9_track: got %b expected %b", dut_v(), exp_v()); end
      if (trk && det < 0) det = mcnt;
      if (key_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok || key_code !== 4'd9 || key_down !== 1'b1)
      begin errors++; $display("FAIL press9_accept: got valid=%b code=%0d down=%b expected 1 9 1", key_valid, key_code, key_down); end
    checks++;
    if (mcnt - det != int'(DT * SD))
      begin errors++; $display("FAIL press9_latency: got %0d cycles expected %0d", mcnt - det, DT * SD); end
    key_ack = 1; step(); key_ack = 0;
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'd9)
      begin errors++; $display("FAIL press9_ack: got valid=%b code=%0d expected 0 9", key_valid, key_code); end
    mask = '0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL release9_track: got %b expected %b", dut_v(), exp_v()); end
      if (key_down === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL release9_timeout: got key_down=%b expected 0", key_down); end
  endtask

  task automatic test_bounce();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (mcnt == 13) mask = 16'h1 << 3;
      if (mcnt == 17) mask = '0;
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL bounce_track: got %b expected %b", dut_v(), exp_v()); end
    end
    checks++;
    if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_down !== 1'b0)
      begin errors++; $display("FAIL bounce_result: got col=%b valid=%b down=%b expected 1110 0 0", col_out, key_valid, key_down); end
  endtask

  // hold a key until it is debounced, then release it until key_down drops
  task automatic tap(input int k, input string nm);
    bit ok;
    for (int ph = 0; ph < 2; ph++) begin
      mask = (ph == 0) ? (16'h1 << k) : '0;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        step(); checks++;
        if (dut_v() !== exp_v()) begin errors++; $display("FAIL %s_track: got %b expected %b", nm, dut_v(), exp_v()); end
        if (key_down === (ph == 0)) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout: got key_down=%b expected %0d", nm, key_down, ph == 0); end
    end
  endtask

  task automatic test_overrun();
    tap(5, "ovr5");
    tap(10, "ovr10");
    checks++;
    if ({key_code, key_valid, overrun} !== {4'd5, 2'b11})
      begin errors++; $display("FAIL overrun_set: got code=%0d valid=%b ovr=%b expected 5 1 1", key_code, key_valid, overrun); end
    key_ack = 1; step(); key_ack = 0;
    checks++;
    if ({key_valid, overrun} !== 2'b00)
      begin errors++; $display("FAIL overrun_ack: got valid=%b ovr=%b expected 0 0", key_valid, overrun); end
  endtask

  task automatic test_ack_coincident();
    bit ok = 0;
    tap(2, "pend2");
    mask = 16'h1 << 7;
    for (int i = 0; i < 200; i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL coinc_track: got %b expected %b", dut_v(), exp_v()); end
      if (trk && armed && !m_down && run == int'(DT) - 1 && (mcnt + 1) % SD == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || {key_code, key_valid} !== {4'd2, 1'b1})
      begin errors++; $display("FAIL coinc_setup: got code=%0d valid=%b expected 2 1", key_code, key_valid); end
    key_ack = 1; step(); key_ack = 0;
    checks++;
    if ({key_code, key_valid, key_down, overrun} !== {4'd7, 3'b110})
      begin errors++; $display("FAIL coinc_accept: got code=%0d valid=%b down=%b ovr=%b expected 7 1 1 0", key_code, key_valid, key_down, overrun); end
    mask = '0;
    for (int i = 0; i < 40; i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL coinc_release: got %b expected %b", dut_v(), exp_v()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    mask = 16'h1 << 12;
    for (int i = 0; i < 100 && !(trk && !m_down); i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL rstmid_track: got %b expected %b", dut_v(), exp_v()); end
    end
    rst = 1; step(); rst = 0;
    checks++;
    if (dut_v() !== {4'b1110, 4'h0, 3'b000})
      begin errors++; $display("FAIL rstmid_values: got %b expected %b", dut_v(), {4'b1110, 4'h0, 3'b000}); end
    for (int i = 0; i < 200; i++) begin
      step(); checks++;
      if (dut_v() !== exp_v()) begin errors++; $display("FAIL rstmid_redetect: got %b expected %b", dut_v(), exp_v()); end
      if (key_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok || key_code !== 4'd12)
      begin errors++; $display("FAIL rstmid_code: got valid=%b code=%0d expected 1 12", key_valid, key_code); end
    key_ack = 1; mask = '0;
    step(); key_ack = 0;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 80; it++) begin
      int sel = $urandom_range(0, 9);
      int hold = $urandom_range(1, 60);
      if (sel < 3) mask = '0;
      else if (sel < 8) mask = 16'h1 << $urandom_range(0, 15);
      else mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      for (int i = 0; i < hold; i++) begin
        key_ack = ($urandom_range(0, 11) == 0);
        step(); checks++;
        if (dut_v() !== exp_v()) begin errors++; $display("FAIL random_track: it %0d got %b expected %b", it, dut_v(), exp_v()); end
      end
    end
    key_ack = 0; mask = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press_ack_release();
    test_bounce();
    test_overrun();
    test_ack_coincident();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
